ram_port_arbiter: RTL and testbench

Two-requester controller for the single-port synchronous RAM (`ram_sp_sr_sw`, bidirectional data bus, cs/we/oe strobes). It arbitrates between an instruction-fetch port (A, read-only) and a load/store port (B, read/write). It sequences each granted access into the RAM's write or registered-read protocol, and owns the tristate data bus on the controller side. It sits between the CPU front/back end and the shared memory.

---
 rtl/ram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port (A fetch read-only, B load/store) arbiter and access sequencer for a single-port sync RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with B over A.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD0  = 2'd2,
    ST_RD1  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;   // 1 = port B owns the access
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   a_rdata_q, b_rdata_q;
  logic                    a_rvalid_q, b_rvalid_q;
  logic                    prio_b;
  logic                    sel_b;
  logic                    cs_c;
  logic                    drive_c;

`ifdef RAM_ARB_RR_EN
  // Pointer set means B wins a tie; reset favours A.
  logic rr_b_q, rr_b_d;

  always_comb begin
    rr_b_d = rr_b_q;
    if (a_gnt) begin
      rr_b_d = 1'b1;
    end else if (b_gnt) begin
      rr_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_b_q <= 1'b0;
    end else begin
      rr_b_q <= rr_b_d;
    end
  end

  assign prio_b = rr_b_q;
`else
  assign prio_b = 1'b1;
`endif

  // Arbitration, next state and RAM strobes
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    cs_c    = 1'b0;
    ram_we  = 1'b0;
    ram_oe  = 1'b0;
    drive_c = 1'b0;
    sel_b   = b_req & (~a_req | prio_b);
    unique case (state_q)
      ST_IDLE: begin
        b_gnt = sel_b;
        a_gnt = a_req & ~sel_b;
        if (b_gnt) begin
          owner_d = 1'b1;
          addr_d  = b_addr;
          wdata_d = b_wdata;
          state_d = b_we ? ST_WR : ST_RD0;
        end else if (a_gnt) begin
          owner_d = 1'b0;
          addr_d  = a_addr;
          state_d = ST_RD0;
        end
      end
      ST_WR: begin
        cs_c    = 1'b1;
        ram_we  = 1'b1;
        drive_c = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD0: begin
        cs_c    = 1'b1;
        ram_oe  = 1'b1;
        state_d = ST_RD1;
      end
      ST_RD1: begin
        cs_c    = 1'b1;
        ram_oe  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read return: RAM drives the bus in RD1, captured into the owner's register only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      if (state_q == ST_RD1) begin
        if (owner_q) begin
          b_rdata_q  <= ram_data;
          b_rvalid_q <= 1'b1;
        end else begin
          a_rdata_q  <= ram_data;
          a_rvalid_q <= 1'b1;
        end
      end
    end
  end

  // Chip select is gated by reset so an interrupted write never commits
  assign ram_cs   = cs_c & rst_n;
  assign ram_addr = addr_q;
  assign ram_data = drive_c ? wdata_q : 'z;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, arbitration table, corner-case sequences, random traffic vs. model.
module tb_ram_port_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 12;

  logic          clk, rst_n;
  logic          a_req, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_cs, ram_we, ram_oe;

  int errors = 0;
  int checks = 0;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM with registered read and bidirectional bus
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_dout_q;

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    if (ram_cs && !ram_we) ram_dout_q <= mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_dout_q : 'z;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the sampling edge and apply the bus-discipline checks
  task automatic tick();
    @(negedge clk);
    if (rst_n && ram_cs) chk("bus_we_oe_exclusive", 64'(ram_we & ram_oe), 64'd0);
    if (rst_n && !ram_cs) chk("bus_idle_strobes", 64'({ram_we, ram_oe}), 64'd0);
    if (rst_n && ram_cs && ram_oe) begin
      chk("bus_read_no_x", 64'($isunknown(ram_data)), 64'd0);
      chk("bus_read_ram_owns", ram_data, ram_dout_q);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    b_we  = 1'b0;
    after_edge();
    after_edge();
    rst_n = 1'b1;
  endtask

  // Returns at the grant-cycle negedge; waited = cycles spent before the grant
  task automatic wait_gnt(input bit port_b, input string name, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((port_b && b_gnt) || (!port_b && a_gnt)) begin
        got = 1'b1;
        break;
      end
      waited++;
      after_edge();
    end
    chk({name, "_gnt"}, 64'(got), 64'd1);
  endtask

  task automatic ram_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int w;
    b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = data;
    wait_gnt(1'b1, "wr", w);
    after_edge();
    b_req = 1'b0; b_we = 1'b0;
    after_edge();
  endtask

  task automatic ram_read(input bit port_b, input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                          input string name, output int waited);
    if (port_b) begin
      b_req = 1'b1; b_we = 1'b0; b_addr = addr;
    end else begin
      a_req = 1'b1; a_addr = addr;
    end
    wait_gnt(port_b, name, waited);
    after_edge();
    a_req = 1'b0; b_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk({name, "_rvalid"}, 64'(port_b ? b_rvalid : a_rvalid), 64'(k == 3));
      chk({name, "_other_rvalid"}, 64'(port_b ? a_rvalid : b_rvalid), 64'd0);
      if (k == 3) chk({name, "_rdata"}, port_b ? b_rdata : a_rdata, exp);
      after_edge();
    end
  endtask

  typedef struct {
    logic a_req;
    logic b_req;
    logic commit;
    logic exp_a_gnt;
    logic exp_b_gnt;
  } arb_vec_t;

  typedef struct {
    int            due;
    bit            port_b;
    logic [DW-1:0] data;
  } rsp_t;

  arb_vec_t      tbl [11];
  rsp_t          rq [$];
  logic [DW-1:0] ref_mem [16];
  bit            rr;

  initial begin
    int w;
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; b_wdata = '0;
`ifdef RAM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    // Reset state
    do_reset();
    tick();
    chk("rst_a_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_b_rvalid", 64'(b_rvalid), 64'd0);
    chk("rst_a_rdata", a_rdata, 64'd0);
    chk("rst_b_rdata", b_rdata, 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_cs", 64'(ram_cs), 64'd0);
    chk("rst_gnt", 64'({a_gnt, b_gnt}), 64'd0);
    after_edge();

    // Arbitration table, applied from a fresh reset (pointer favours A)
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, rr,   !rr};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, rr,   !rr};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, rr,   !rr};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      a_req = tbl[i].a_req; a_addr = 12'h010;
      b_req = tbl[i].b_req; b_we = 1'b0; b_addr = 12'h020;
      tick();
      chk($sformatf("tbl%0d_a_gnt", i), 64'(a_gnt), 64'(tbl[i].exp_a_gnt));
      chk($sformatf("tbl%0d_b_gnt", i), 64'(b_gnt), 64'(tbl[i].exp_b_gnt));
      if (tbl[i].commit) begin
        after_edge();
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) after_edge();
      end else begin
        a_req = 1'b0; b_req = 1'b0;
        after_edge();
      end
    end

    // B write then A read of the same word, A asking in the first free cycle
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h018; b_wdata = 64'h1234;
    wait_gnt(1'b1, "seqA_b", w);
    after_edge();
    b_req = 1'b0; b_we = 1'b0;
    tick();
    chk("seqA_wr_cs", 64'(ram_cs), 64'd1);
    chk("seqA_wr_we", 64'(ram_we), 64'd1);
    chk("seqA_wr_oe", 64'(ram_oe), 64'd0);
    chk("seqA_wr_addr", 64'(ram_addr), 64'h018);
    chk("seqA_wr_data", ram_data, 64'h1234);
    after_edge();
    ram_read(1'b0, 12'h018, 64'h1234, "seqA_a", w);
    chk("seqA_a_wait", 64'(w), 64'd0);

    // Simultaneous reads after reset
    ram_write(12'h000, 64'hA5);
    ram_write(12'h101, 64'h123456789AB);
    do_reset();
    a_req = 1'b1; a_addr = 12'h000;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h101;
    for (int k = 0; k < 8; k++) begin
      bit ag, bg;
      tick();
      ag = a_gnt; bg = b_gnt;
      chk($sformatf("seqB_k%0d_a_gnt", k), 64'(a_gnt), 64'(rr ? (k == 0) : (k == 3)));
      chk($sformatf("seqB_k%0d_b_gnt", k), 64'(b_gnt), 64'(rr ? (k == 3) : (k == 0)));
      chk($sformatf("seqB_k%0d_a_rvalid", k), 64'(a_rvalid), 64'(rr ? (k == 3) : (k == 6)));
      chk($sformatf("seqB_k%0d_b_rvalid", k), 64'(b_rvalid), 64'(rr ? (k == 6) : (k == 3)));
      if (k == (rr ? 3 : 6)) chk("seqB_a_rdata", a_rdata, 64'hA5);
      if (k == (rr ? 6 : 3)) chk("seqB_b_rdata", b_rdata, 64'h123456789AB);
      after_edge();
      if (ag) a_req = 1'b0;
      if (bg) b_req = 1'b0;
    end

    // Both ports requesting permanently
    begin
      bit gp [8];
      int n;
      n = 0;
      do_reset();
      a_req = 1'b1; a_addr = 12'h000;
      b_req = 1'b1; b_we = 1'b0; b_addr = 12'h101;
      for (int k = 0; k < 40 && n < 8; k++) begin
        tick();
        if (a_gnt && b_gnt) chk("seqC_double_gnt", 64'd1, 64'd0);
        if (a_gnt || b_gnt) begin
          gp[n] = b_gnt;
          n++;
        end
        after_edge();
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("seqC_grant_count", 64'(n), 64'd8);
      for (int i = 0; i < n; i++)
        chk($sformatf("seqC_grant%0d_port_b", i), 64'(gp[i]), 64'(rr ? (i % 2 == 1) : 1'b1));
      repeat (4) after_edge();
    end

    // Reset during the WR cycle of a write
    ram_write(12'h005, 64'h0);
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h005; b_wdata = 64'hDEAD;
    wait_gnt(1'b1, "seqD_b", w);
    after_edge();
    b_req = 1'b0; b_we = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("seqD_cs_gated", 64'(ram_cs), 64'd0);
    after_edge();
    rst_n = 1'b1;
    tick();
    chk("seqD_ram_addr", 64'(ram_addr), 64'd0);
    chk("seqD_rvalids", 64'({a_rvalid, b_rvalid}), 64'd0);
    chk("seqD_a_rdata", a_rdata, 64'd0);
    chk("seqD_b_rdata", b_rdata, 64'd0);
    chk("seqD_cs", 64'(ram_cs), 64'd0);
    chk("seqD_gnt", 64'({a_gnt, b_gnt}), 64'd0);
    after_edge();
    ram_read(1'b1, 12'h005, 64'h0, "seqD_rd", w);

    // Reset during RD1 of a B read
    ram_read(1'b1, 12'h101, 64'h123456789AB, "seqE_pre", w);
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h000;
    wait_gnt(1'b1, "seqE_b", w);
    after_edge();
    b_req = 1'b0;
    tick();
    after_edge();
    rst_n = 1'b0;
    tick();
    after_edge();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("seqE_k%0d_rvalids", k), 64'({a_rvalid, b_rvalid}), 64'd0);
      chk($sformatf("seqE_k%0d_b_rdata", k), b_rdata, 64'd0);
      after_edge();
    end
    ram_read(1'b0, 12'h101, 64'h123456789AB, "seqE_post", w);
    chk("seqE_post_wait", 64'(w), 64'd0);

    // Random traffic against a transaction-level model
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      ram_write(12'h0F0 + 12'(i), d);
      ref_mem[i] = d;
    end
    do_reset();
    begin
      int  busy;
      bit  last_b;
      busy = 0;
      last_b = 1'b1;
      rq.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
        bit eag, ebg, eav, ebv;
        logic [DW-1:0] ed;
        tick();
        eag = 1'b0; ebg = 1'b0;
        if (busy == 0) begin
          if (a_req && b_req) begin
            ebg = rr ? !last_b : 1'b1;
            eag = !ebg;
          end else begin
            eag = a_req;
            ebg = b_req;
          end
        end
        chk("rnd_a_gnt", 64'(a_gnt), 64'(eag));
        chk("rnd_b_gnt", 64'(b_gnt), 64'(ebg));
        eav = 1'b0; ebv = 1'b0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          eav = !rq[0].port_b;
          ebv = rq[0].port_b;
          ed  = rq[0].data;
          void'(rq.pop_front());
        end
        chk("rnd_a_rvalid", 64'(a_rvalid), 64'(eav));
        chk("rnd_b_rvalid", 64'(b_rvalid), 64'(ebv));
        if (eav) chk("rnd_a_rdata", a_rdata, ed);
        if (ebv) chk("rnd_b_rdata", b_rdata, ed);
        if (eag || ebg) begin
          last_b = ebg;
          if (ebg && b_we) begin
            ref_mem[b_addr[3:0]] = b_wdata;
            busy = 1;
          end else begin
            rq.push_back('{cyc + 3, ebg, ref_mem[ebg ? b_addr[3:0] : a_addr[3:0]]});
            busy = 2;
          end
        end else if (busy > 0) begin
          busy--;
        end
        after_edge();
        if (eag) a_req = 1'b0;
        if (ebg) b_req = 1'b0;
        if (!a_req && $urandom_range(0, 1) == 1) begin
          a_req = 1'b1;
          a_addr = 12'h0F0 + 12'($urandom_range(0, 15));
        end
        if (!b_req && $urandom_range(0, 1) == 1) begin
          b_req = 1'b1;
          b_we = 1'($urandom_range(0, 1));
          b_addr = 12'h0F0 + 12'($urandom_range(0, 15));
          b_wdata = {$urandom, $urandom};
        end
      end
      a_req = 1'b0; b_req = 1'b0;
      repeat (4) after_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
